// File: rtl/overture_io_port.sv
// Byte-wide I/O peripheral for the Overture CPU: a host-to-CPU input FIFO and a CPU-to-host output FIFO.
// Sticky error flags exist only when OVERTURE_IO_ERR_EN is defined; otherwise both flags are tied to 0.
module overture_io_port #(
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [7:0]                   host_in_data,
  input  logic                         host_in_valid,
  output logic                         host_in_ready,
  output logic [7:0]                   cpu_in_data,
  output logic                         cpu_in_avail,
  input  logic                         cpu_in_rd,
  input  logic [7:0]                   cpu_out_data,
  input  logic                         cpu_out_wr,
  output logic [7:0]                   host_out_data,
  output logic                         host_out_valid,
  input  logic                         host_out_ready,
  output logic [$clog2(IN_DEPTH):0]    in_count,
  output logic [$clog2(OUT_DEPTH):0]   out_count,
  output logic                         err_underflow,
  output logic                         err_overflow
);

  localparam int IAW = $clog2(IN_DEPTH);
  localparam int OAW = $clog2(OUT_DEPTH);
  localparam logic [IAW:0] IN_FULL  = (IAW + 1)'(IN_DEPTH);
  localparam logic [OAW:0] OUT_FULL = (OAW + 1)'(OUT_DEPTH);

  logic [7:0]     in_mem_q  [IN_DEPTH];
  logic [7:0]     out_mem_q [OUT_DEPTH];
  logic [IAW-1:0] in_rd_ptr_q,  in_rd_ptr_d,  in_wr_ptr_q,  in_wr_ptr_d;
  logic [OAW-1:0] out_rd_ptr_q, out_rd_ptr_d, out_wr_ptr_q, out_wr_ptr_d;
  logic [IAW:0]   in_count_q,  in_count_d;
  logic [OAW:0]   out_count_q, out_count_d;

  logic in_push, in_pop, out_push, out_pop;

  // Flow-control outputs come only from registered occupancy.
  assign host_in_ready  = (in_count_q != IN_FULL);
  assign cpu_in_avail   = (in_count_q != '0);
  assign host_out_valid = (out_count_q != '0);

  assign cpu_in_data   = cpu_in_avail   ? in_mem_q[in_rd_ptr_q]   : 8'h00;
  assign host_out_data = host_out_valid ? out_mem_q[out_rd_ptr_q] : 8'h00;

  assign in_push  = host_in_valid && host_in_ready;
  assign in_pop   = cpu_in_rd && cpu_in_avail;
  assign out_pop  = host_out_valid && host_out_ready;
  // A full output FIFO still takes a write when the host drains the head in the same cycle.
  assign out_push = cpu_out_wr && ((out_count_q != OUT_FULL) || out_pop);

  assign in_count  = in_count_q;
  assign out_count = out_count_q;

  always_comb begin
    in_rd_ptr_d = in_pop  ? in_rd_ptr_q + 1'b1 : in_rd_ptr_q;
    in_wr_ptr_d = in_push ? in_wr_ptr_q + 1'b1 : in_wr_ptr_q;
    in_count_d  = in_count_q;
    case ({in_push, in_pop})
      2'b10:   in_count_d = in_count_q + 1'b1;
      2'b01:   in_count_d = in_count_q - 1'b1;
      default: in_count_d = in_count_q;
    endcase
  end

  always_comb begin
    out_rd_ptr_d = out_pop  ? out_rd_ptr_q + 1'b1 : out_rd_ptr_q;
    out_wr_ptr_d = out_push ? out_wr_ptr_q + 1'b1 : out_wr_ptr_q;
    out_count_d  = out_count_q;
    case ({out_push, out_pop})
      2'b10:   out_count_d = out_count_q + 1'b1;
      2'b01:   out_count_d = out_count_q - 1'b1;
      default: out_count_d = out_count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_rd_ptr_q  <= '0;
      in_wr_ptr_q  <= '0;
      in_count_q   <= '0;
      out_rd_ptr_q <= '0;
      out_wr_ptr_q <= '0;
      out_count_q  <= '0;
    end else begin
      in_rd_ptr_q  <= in_rd_ptr_d;
      in_wr_ptr_q  <= in_wr_ptr_d;
      in_count_q   <= in_count_d;
      out_rd_ptr_q <= out_rd_ptr_d;
      out_wr_ptr_q <= out_wr_ptr_d;
      out_count_q  <= out_count_d;
    end
  end

  // Storage needs no reset: the head is masked to 8'h00 whenever a FIFO is empty.
  always_ff @(posedge clk) begin
    if (in_push)  in_mem_q[in_wr_ptr_q]   <= host_in_data;
    if (out_push) out_mem_q[out_wr_ptr_q] <= cpu_out_data;
  end

`ifdef OVERTURE_IO_ERR_EN
  logic err_underflow_q, err_overflow_q;
  logic underflow_evt, overflow_evt;

  assign underflow_evt = cpu_in_rd && !cpu_in_avail;
  assign overflow_evt  = cpu_out_wr && !out_push;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_underflow_q <= 1'b0;
      err_overflow_q  <= 1'b0;
    end else begin
      if (underflow_evt) err_underflow_q <= 1'b1;
      if (overflow_evt)  err_overflow_q  <= 1'b1;
    end
  end

  assign err_underflow = err_underflow_q;
  assign err_overflow  = err_overflow_q;
`else
  assign err_underflow = 1'b0;
  assign err_overflow  = 1'b0;
`endif

endmodule

// File: tb/tb_overture_io_port.sv
// Directed, table-driven bench for overture_io_port (IN_DEPTH = OUT_DEPTH = 4).
// Each vector's expected values describe the outputs just before the clock edge that applies its inputs.
module tb_overture_io_port;

`ifdef OVERTURE_IO_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] host_in_data = 8'h00;
  logic       host_in_valid = 1'b0;
  logic       host_in_ready;
  logic [7:0] cpu_in_data;
  logic       cpu_in_avail;
  logic       cpu_in_rd = 1'b0;
  logic [7:0] cpu_out_data = 8'h00;
  logic       cpu_out_wr = 1'b0;
  logic [7:0] host_out_data;
  logic       host_out_valid;
  logic       host_out_ready = 1'b0;
  logic [2:0] in_count;
  logic [2:0] out_count;
  logic       err_underflow;
  logic       err_overflow;

  int total = 0;
  int bad = 0;

  overture_io_port #(.IN_DEPTH(4), .OUT_DEPTH(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .host_in_data   (host_in_data),
    .host_in_valid  (host_in_valid),
    .host_in_ready  (host_in_ready),
    .cpu_in_data    (cpu_in_data),
    .cpu_in_avail   (cpu_in_avail),
    .cpu_in_rd      (cpu_in_rd),
    .cpu_out_data   (cpu_out_data),
    .cpu_out_wr     (cpu_out_wr),
    .host_out_data  (host_out_data),
    .host_out_valid (host_out_valid),
    .host_out_ready (host_out_ready),
    .in_count       (in_count),
    .out_count      (out_count),
    .err_underflow  (err_underflow),
    .err_overflow   (err_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       hiv;
    logic [7:0] hid;
    logic       rd;
    logic       wr;
    logic [7:0] od;
    logic       hor;
    logic [2:0] e_ic;
    logic [2:0] e_oc;
    logic [7:0] e_cid;
    logic       e_cav;
    logic       e_hir;
    logic       e_hov;
    logic [7:0] e_hod;
    logic       e_eu;
    logic       e_eo;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec=%0d actual=%h required=%h", name, idx, act, exp);
    end
  endtask

  task automatic check_reset_values(input int idx);
    chk("rst_in_count",   idx, {5'b0, in_count},        8'h00);
    chk("rst_out_count",  idx, {5'b0, out_count},       8'h00);
    chk("rst_hin_ready",  idx, {7'b0, host_in_ready},   8'h01);
    chk("rst_cin_avail",  idx, {7'b0, cpu_in_avail},    8'h00);
    chk("rst_cin_data",   idx, cpu_in_data,             8'h00);
    chk("rst_hout_valid", idx, {7'b0, host_out_valid},  8'h00);
    chk("rst_hout_data",  idx, host_out_data,           8'h00);
    chk("rst_err_under",  idx, {7'b0, err_underflow},   8'h00);
    chk("rst_err_over",   idx, {7'b0, err_overflow},    8'h00);
  endtask

  task automatic drive(input logic hiv, input logic [7:0] hid, input logic rd,
                       input logic wr, input logic [7:0] od, input logic hor);
    host_in_valid  = hiv;
    host_in_data   = hid;
    cpu_in_rd      = rd;
    cpu_out_wr     = wr;
    cpu_out_data   = od;
    host_out_ready = hor;
  endtask

  initial begin
    //                hiv hid    rd  wr  od     hor  ic  oc  cid    cav hir hov hod    eu  eo
    // Three pushes, then three reads.
    vecs.push_back('{1, 8'h11, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0});
    vecs.push_back('{1, 8'h22, 0, 0, 8'h00, 0, 1, 0, 8'h11, 1, 1, 0, 8'h00, 0, 0});
    vecs.push_back('{1, 8'h33, 0, 0, 8'h00, 0, 2, 0, 8'h11, 1, 1, 0, 8'h00, 0, 0});
    vecs.push_back('{0, 8'h00, 0, 0, 8'h00, 0, 3, 0, 8'h11, 1, 1, 0, 8'h00, 0, 0});
    vecs.push_back('{0, 8'h00, 1, 0, 8'h00, 0, 3, 0, 8'h11, 1, 1, 0, 8'h00, 0, 0});
    vecs.push_back('{0, 8'h00, 1, 0, 8'h00, 0, 2, 0, 8'h22, 1, 1, 0, 8'h00, 0, 0});
    vecs.push_back('{0, 8'h00, 1, 0, 8'h00, 0, 1, 0, 8'h33, 1, 1, 0, 8'h00, 0, 0});
    vecs.push_back('{0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0});
    // host_in_valid held for six cycles; ready drops after the fourth accept.
    vecs.push_back('{1, 8'h01, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0});
    vecs.push_back('{1, 8'h02, 0, 0, 8'h00, 0, 1, 0, 8'h01, 1, 1, 0, 8'h00, 0, 0});
    vecs.push_back('{1, 8'h03, 0, 0, 8'h00, 0, 2, 0, 8'h01, 1, 1, 0, 8'h00, 0, 0});
    vecs.push_back('{1, 8'h04, 0, 0, 8'h00, 0, 3, 0, 8'h01, 1, 1, 0, 8'h00, 0, 0});
    vecs.push_back('{1, 8'h05, 0, 0, 8'h00, 0, 4, 0, 8'h01, 1, 0, 0, 8'h00, 0, 0});
    vecs.push_back('{1, 8'h06, 0, 0, 8'h00, 0, 4, 0, 8'h01, 1, 0, 0, 8'h00, 0, 0});
    vecs.push_back('{1, 8'h05, 1, 0, 8'h00, 0, 4, 0, 8'h01, 1, 0, 0, 8'h00, 0, 0});
    vecs.push_back('{1, 8'h05, 0, 0, 8'h00, 0, 3, 0, 8'h02, 1, 1, 0, 8'h00, 0, 0});
    vecs.push_back('{0, 8'h00, 0, 0, 8'h00, 0, 4, 0, 8'h02, 1, 0, 0, 8'h00, 0, 0});
    vecs.push_back('{0, 8'h00, 1, 0, 8'h00, 0, 4, 0, 8'h02, 1, 0, 0, 8'h00, 0, 0});
    vecs.push_back('{0, 8'h00, 1, 0, 8'h00, 0, 3, 0, 8'h03, 1, 1, 0, 8'h00, 0, 0});
    vecs.push_back('{0, 8'h00, 1, 0, 8'h00, 0, 2, 0, 8'h04, 1, 1, 0, 8'h00, 0, 0});
    vecs.push_back('{0, 8'h00, 1, 0, 8'h00, 0, 1, 0, 8'h05, 1, 1, 0, 8'h00, 0, 0});
    vecs.push_back('{0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0});
    // Read on an empty input FIFO.
    vecs.push_back('{0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0});
    vecs.push_back('{0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 1, 0, 8'h00, 1, 0});
    // Five CPU writes with the host stalled; A4 is dropped.
    vecs.push_back('{0, 8'h00, 0, 1, 8'hA0, 0, 0, 0, 8'h00, 0, 1, 0, 8'h00, 1, 0});
    vecs.push_back('{0, 8'h00, 0, 1, 8'hA1, 0, 0, 1, 8'h00, 0, 1, 1, 8'hA0, 1, 0});
    vecs.push_back('{0, 8'h00, 0, 1, 8'hA2, 0, 0, 2, 8'h00, 0, 1, 1, 8'hA0, 1, 0});
    vecs.push_back('{0, 8'h00, 0, 1, 8'hA3, 0, 0, 3, 8'h00, 0, 1, 1, 8'hA0, 1, 0});
    vecs.push_back('{0, 8'h00, 0, 1, 8'hA4, 0, 0, 4, 8'h00, 0, 1, 1, 8'hA0, 1, 0});
    vecs.push_back('{0, 8'h00, 0, 0, 8'h00, 0, 0, 4, 8'h00, 0, 1, 1, 8'hA0, 1, 1});
    // Full output FIFO: write and drain in the same cycle, then drain the rest.
    vecs.push_back('{0, 8'h00, 0, 1, 8'hB5, 1, 0, 4, 8'h00, 0, 1, 1, 8'hA0, 1, 1});
    vecs.push_back('{0, 8'h00, 0, 0, 8'h00, 0, 0, 4, 8'h00, 0, 1, 1, 8'hA1, 1, 1});
    vecs.push_back('{0, 8'h00, 0, 0, 8'h00, 1, 0, 4, 8'h00, 0, 1, 1, 8'hA1, 1, 1});
    vecs.push_back('{0, 8'h00, 0, 0, 8'h00, 1, 0, 3, 8'h00, 0, 1, 1, 8'hA2, 1, 1});
    vecs.push_back('{0, 8'h00, 0, 0, 8'h00, 1, 0, 2, 8'h00, 0, 1, 1, 8'hA3, 1, 1});
    vecs.push_back('{0, 8'h00, 0, 0, 8'h00, 1, 0, 1, 8'h00, 0, 1, 1, 8'hB5, 1, 1});
    vecs.push_back('{0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 1, 0, 8'h00, 1, 1});

    repeat (2) @(negedge clk);
    #1 check_reset_values(-1);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].hiv, vecs[i].hid, vecs[i].rd, vecs[i].wr, vecs[i].od, vecs[i].hor);
      #1;
      chk("in_count",   i, {5'b0, in_count},       {5'b0, vecs[i].e_ic});
      chk("out_count",  i, {5'b0, out_count},      {5'b0, vecs[i].e_oc});
      chk("cpu_in_data", i, cpu_in_data,           vecs[i].e_cid);
      chk("cpu_in_avail", i, {7'b0, cpu_in_avail}, {7'b0, vecs[i].e_cav});
      chk("host_in_ready", i, {7'b0, host_in_ready}, {7'b0, vecs[i].e_hir});
      chk("host_out_valid", i, {7'b0, host_out_valid}, {7'b0, vecs[i].e_hov});
      chk("host_out_data", i, host_out_data,       vecs[i].e_hod);
      chk("err_underflow", i, {7'b0, err_underflow}, {7'b0, vecs[i].e_eu & ERR_EN});
      chk("err_overflow",  i, {7'b0, err_overflow},  {7'b0, vecs[i].e_eo & ERR_EN});
      $display("vec %0d: ic=%0d oc=%0d cid=%h hod=%h", i, in_count, out_count, cpu_in_data, host_out_data);
    end

    // Mid-cycle asynchronous reset with two bytes in each FIFO.
    @(negedge clk); drive(1, 8'hC1, 0, 1, 8'hD1, 0);
    @(negedge clk); drive(1, 8'hC2, 0, 1, 8'hD2, 0);
    @(negedge clk); drive(0, 8'h00, 0, 0, 8'h00, 0);
    #1;
    chk("pre_rst_in_count",  100, {5'b0, in_count},  8'h02);
    chk("pre_rst_out_count", 100, {5'b0, out_count}, 8'h02);
    chk("pre_rst_cin_data",  100, cpu_in_data,       8'hC1);
    chk("pre_rst_hout_data", 100, host_out_data,     8'hD1);
    $display("pre-reset: ic=%0d oc=%0d cid=%h hod=%h", in_count, out_count, cpu_in_data, host_out_data);
    @(posedge clk);
    #2 reset = 1'b0;
    #1 check_reset_values(101);
    $display("async reset: ic=%0d oc=%0d ready=%0d", in_count, out_count, host_in_ready);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); drive(1, 8'h5A, 0, 0, 8'h00, 0);
    @(negedge clk); drive(0, 8'h00, 0, 0, 8'h00, 0);
    #1;
    chk("post_rst_in_count", 102, {5'b0, in_count},     8'h01);
    chk("post_rst_cin_data", 102, cpu_in_data,          8'h5A);
    chk("post_rst_cin_avail", 102, {7'b0, cpu_in_avail}, 8'h01);
    $display("post-reset push: ic=%0d cid=%h", in_count, cpu_in_data);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
